i2c_sequencer: RTL and testbench

Parametrised ROM-driven I2C command sequencer, next generation of the single-format init controller. Walks a command ROM from a selectable start address, issuing variable-length writes, timed delays and an explicit end marker, with NACK retry and error reporting. Sits between the top-level bring-up logic (for example, the HDMI transmitter init) and the team's `i2c` byte engine. The engine and ROM are external to this block.

---
 rtl/i2c_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sequencer
// Description : ROM-driven I2C command sequencer. Walks a command ROM from a
//               selectable start address, issuing variable-length WRITEs,
//               timed DELAYs and an explicit END marker, with NACK handling
//               and error reporting. Drives an external i2c byte engine.
//               Optional feature macro: I2C_SEQ_RETRY_EN (NACK retry with up
//               to MAX_RETRY re-sends per WRITE entry).
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sequencer #(
    parameter int NBYTES_MAX = 4,
    parameter int DEPTH      = 64,
    parameter int DELAY_UNIT = 1000,
    parameter int MAX_RETRY  = 3,
    localparam int AW        = $clog2(DEPTH),
    localparam int EW        = 8 + NBYTES_MAX*8,
    localparam int NBW       = $clog2(NBYTES_MAX+1),
    localparam int PW        = NBYTES_MAX*8
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           start_i,
    input  logic [AW-1:0]  start_addr_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o,
    output logic [AW-1:0]  err_addr_o,
    output logic [AW-1:0]  rom_addr_o,
    input  logic [EW-1:0]  rom_data_i,
    output logic           i2c_send_o,
    output logic [NBW-1:0] i2c_nbytes_o,
    output logic [PW-1:0]  i2c_data_o,
    input  logic           i2c_ready_i,
    input  logic           i2c_done_i,
    input  logic           i2c_nack_i
);

    // Delay counter must hold the largest load, 63*DELAY_UNIT-1.
    localparam int DW = $clog2(63*DELAY_UNIT+1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_WAIT      = 3'd4;
    localparam logic [2:0] S_DELAY     = 3'd5;
    localparam logic [2:0] S_RETRY_CHK = 3'd6;
    localparam logic [2:0] S_ADVANCE   = 3'd7;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_END   = 2'b10;

    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH-1);
    localparam logic [DW-1:0] C_UNIT      = DW'(DELAY_UNIT);
    localparam logic [5:0]    C_NBMAX     = 6'(NBYTES_MAX);

    logic [2:0]     state_q,    state_d;
    logic [AW-1:0]  addr_q,     addr_d;
    logic           done_q,     done_d;
    logic           err_q,      err_d;
    logic [AW-1:0]  err_addr_q, err_addr_d;
    logic [NBW-1:0] nbytes_q,   nbytes_d;
    logic [PW-1:0]  data_q,     data_d;
    logic [DW-1:0]  cnt_q,      cnt_d;
    logic           nack_q,     nack_d;
`ifdef I2C_SEQ_RETRY_EN
    logic [3:0]     retry_q,    retry_d;
`endif

    // Entry field split of the ROM word presented during DECODE.
    logic [1:0]    w_op;
    logic [5:0]    w_len;
    logic [PW-1:0] w_payload;
    logic          w_len_ok;
    logic [DW-1:0] w_delay_load;

    assign w_op         = rom_data_i[EW-1:EW-2];
    assign w_len        = rom_data_i[EW-3:EW-8];
    assign w_payload    = rom_data_i[PW-1:0];
    assign w_len_ok     = (w_len != 6'd0) && (w_len <= C_NBMAX);
    assign w_delay_load = (DW'(w_len) * C_UNIT) - DW'(1);

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_addr_o   = err_addr_q;
    assign rom_addr_o   = addr_q;
    assign i2c_nbytes_o = nbytes_q;
    assign i2c_data_o   = data_q;
    // Request is combinational so it lands in the first SEND cycle the engine is idle.
    assign i2c_send_o   = (state_q == S_SEND) && i2c_ready_i;

    // Next-state and datapath update for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        nbytes_d   = nbytes_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        nack_d     = nack_q;
`ifdef I2C_SEQ_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = start_addr_i;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // addr_q already drives the ROM; data is valid next cycle.
                state_d = S_DECODE;
            end
            S_DECODE: begin
                nbytes_d = w_len[NBW-1:0];
                data_d   = w_payload;
`ifdef I2C_SEQ_RETRY_EN
                retry_d  = 4'd0;
`endif
                case (w_op)
                    OP_WRITE: begin
                        if (w_len_ok) begin
                            state_d = S_SEND;
                        end else begin
                            err_d      = 1'b1;
                            err_addr_d = addr_q;
                            state_d    = S_IDLE;
                        end
                    end
                    OP_DELAY: begin
                        if (w_len != 6'd0) begin
                            cnt_d   = w_delay_load;
                            state_d = S_DELAY;
                        end else begin
                            state_d = S_ADVANCE;
                        end
                    end
                    OP_END: begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                        state_d    = S_IDLE;
                    end
                endcase
            end
            S_SEND: begin
                if (i2c_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i2c_done_i) begin
                    nack_d  = i2c_nack_i;
                    state_d = S_RETRY_CHK;
                end
            end
            S_RETRY_CHK: begin
                if (!nack_q) begin
                    state_d = S_ADVANCE;
                end else begin
`ifdef I2C_SEQ_RETRY_EN
                    if (retry_q < 4'(MAX_RETRY)) begin
                        retry_d = retry_q + 4'd1;
                        state_d = S_SEND;
                    end else begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                        state_d    = S_IDLE;
                    end
`else
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = S_IDLE;
`endif
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = S_ADVANCE;
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            S_ADVANCE: begin
                // Last ROM entry acts as an implicit END; the address never wraps.
                if (addr_q == C_LAST_ADDR) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears every output.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            nbytes_q   <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            nbytes_q   <= nbytes_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            nack_q     <= nack_d;
        end
    end

`ifdef I2C_SEQ_RETRY_EN
    // Per-entry retry counter, cleared on every DECODE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            retry_q <= 4'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_sequencer
// Description : Self-checking bench for i2c_sequencer with a ROM model, an
//               engine responder and a command-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_sequencer;

    localparam int NB    = 4;
    localparam int DEPTH = 64;
    localparam int DU    = 10;
    localparam int MR    = 3;
    localparam int AW    = 6;
    localparam int EW    = 40;
    localparam int NBW   = 3;
`ifdef I2C_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           rst_n_i = 1'b0;
    logic           start_i = 1'b0;
    logic [AW-1:0]  start_addr_i = '0;
    logic           busy_o, done_o, err_o, i2c_send_o;
    logic [AW-1:0]  err_addr_o, rom_addr_o;
    logic [EW-1:0]  rom_data_i = '0;
    logic [NBW-1:0] i2c_nbytes_o;
    logic [31:0]    i2c_data_o;
    logic           i2c_ready_i, i2c_done_i, i2c_nack_i;

    logic [EW-1:0] rom [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    i2c_sequencer #(.NBYTES_MAX(NB), .DEPTH(DEPTH), .DELAY_UNIT(DU), .MAX_RETRY(MR)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .start_addr_i(start_addr_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_addr_o(err_addr_o),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .i2c_send_o(i2c_send_o),
        .i2c_nbytes_o(i2c_nbytes_o), .i2c_data_o(i2c_data_o), .i2c_ready_i(i2c_ready_i),
        .i2c_done_i(i2c_done_i), .i2c_nack_i(i2c_nack_i)
    );

    always #5 clk_i = ~clk_i;

    // ROM with one-cycle read latency
    always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

    // Engine responder: accepts a send, answers after a random latency
    bit nack_plan[$];
    bit eng_busy, eng_hold, ready_all;
    int eng_lat;
    always @(posedge clk_i or negedge rst_n_i) begin
        bit nk;
        if (!rst_n_i) begin
            eng_busy <= 1'b0; eng_lat <= 0;
            i2c_done_i <= 1'b0; i2c_nack_i <= 1'b0; i2c_ready_i <= 1'b0;
        end else begin
            i2c_done_i <= 1'b0;
            i2c_nack_i <= 1'b0;
            if (i2c_send_o) begin
                eng_busy <= 1'b1;
                eng_lat <= int'($urandom_range(1, 4));
                i2c_ready_i <= 1'b0;
            end else if (eng_busy) begin
                i2c_ready_i <= 1'b0;
                if (!eng_hold) begin
                    if (eng_lat <= 1) begin
                        if (nack_plan.size() > 0) nk = nack_plan.pop_front();
                        else nk = 1'b0;
                        eng_busy <= 1'b0;
                        i2c_done_i <= 1'b1;
                        i2c_nack_i <= nk;
                    end else begin
                        eng_lat <= eng_lat - 1;
                    end
                end
            end else begin
                i2c_ready_i <= ready_all ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Output monitor, sampled on the falling edge
    int cyc = 0, start_cyc = -1, done_cyc = -1, n_done = 0, n_both = 0;
    bit saw_zero = 1'b0;
    logic [NBW-1:0] act_len[$];
    logic [31:0]    act_data[$];
    int             send_cyc[$];
    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (start_i && start_cyc < 0) start_cyc = cyc;
        if (i2c_send_o) begin
            act_len.push_back(i2c_nbytes_o);
            act_data.push_back(i2c_data_o);
            send_cyc.push_back(cyc);
        end
        if (done_o) begin n_done = n_done + 1; done_cyc = cyc; end
        if (done_o && err_o) n_both = n_both + 1;
        if (busy_o && rom_addr_o == '0) saw_zero = 1'b1;
    end

    // Reference model: command-level walk of the ROM
    int exp_len[$];
    logic [31:0] exp_data[$];

    function automatic logic [EW-1:0] mk(input logic [1:0] op, input logic [5:0] len, input logic [31:0] pl);
        return {op, len, pl};
    endfunction

    task automatic predict(input int start, output bit e_err, output int e_addr);
        int a, op, len, tries;
        bit nk, fin;
        bit plan[$];
        logic [EW-1:0] e;
        plan = nack_plan;
        a = start; e_err = 1'b0; e_addr = 0; fin = 1'b0;
        exp_len.delete(); exp_data.delete();
        while (!fin) begin
            e = rom[a]; op = int'(e[39:38]); len = int'(e[37:32]);
            if (op == 2) begin
                fin = 1'b1;
            end else if (op == 3 || (op == 0 && (len == 0 || len > NB))) begin
                e_err = 1'b1; e_addr = a; fin = 1'b1;
            end else begin
                if (op == 0) begin
                    tries = 0;
                    forever begin
                        exp_len.push_back(len); exp_data.push_back(e[31:0]);
                        nk = (plan.size() > 0) ? plan.pop_front() : 1'b0;
                        if (!nk) break;
                        if (RETRY_EN && tries < MR) tries++;
                        else begin e_err = 1'b1; e_addr = a; fin = 1'b1; break; end
                    end
                end
                if (!fin) begin
                    if (a == DEPTH-1) fin = 1'b1;
                    else a++;
                end
            end
        end
    endtask

    task automatic rom_clear();
        for (int i = 0; i < DEPTH; i++) rom[i] = mk(2'b10, 6'd0, 32'h0);
    endtask

    task automatic kick(input int start);
        act_len.delete(); act_data.delete(); send_cyc.delete();
        n_done = 0; n_both = 0; saw_zero = 1'b0; start_cyc = -1; done_cyc = -1;
        @(posedge clk_i); #2;
        start_addr_i = AW'(start); start_i = 1'b1;
        @(posedge clk_i); #2;
        start_i = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i); #1;
            if (n_done > 0 || err_o) begin timeout = 1'b0; break; end
        end
        repeat (3) @(negedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        @(negedge clk_i); #1;
        n_checks++;
        if ({busy_o, done_o, err_o, err_addr_o, rom_addr_o, i2c_send_o, i2c_nbytes_o, i2c_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b eaddr=%0d raddr=%0d send=%b nb=%0d data=%h, want all 0",
                     busy_o, done_o, err_o, err_addr_o, rom_addr_o, i2c_send_o, i2c_nbytes_o, i2c_data_o);
        end
    endtask

    task automatic test_basic();
        bit to;
        rom_clear(); ready_all = 1'b1;
        rom[0] = mk(2'b00, 6'd3, 32'h72083500);
        rom[1] = mk(2'b10, 6'd0, 32'h0);
        kick(0); wait_end(200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: got no completion, want done"); end
        n_checks++; if (act_len.size() !== 1) begin n_fail++; $display("FAIL basic_nsend: got %0d want 1", act_len.size()); end
        if (act_len.size() > 0) begin
            n_checks++; if (send_cyc[0] - start_cyc !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", send_cyc[0] - start_cyc); end
            n_checks++; if (act_len[0] !== 3'd3) begin n_fail++; $display("FAIL basic_nbytes: got %0d want 3", act_len[0]); end
            n_checks++; if (act_data[0][31:8] !== 24'h720835) begin n_fail++; $display("FAIL basic_data: got %h want 720835", act_data[0][31:8]); end
        end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", n_done); end
        n_checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy=%b err=%b want 0 0", busy_o, err_o); end
    endtask

    task automatic test_delay();
        bit to;
        rom_clear(); ready_all = 1'b0;
        rom[5] = mk(2'b01, 6'd4, 32'h0);
        rom[6] = mk(2'b10, 6'd0, 32'h0);
        kick(5); wait_end(200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL delay_timeout: got no completion, want done"); end
        // start(0) FETCH(1) DECODE(2) DELAY(3..42) ADVANCE FETCH DECODE, done in cycle 46
        n_checks++; if (done_cyc - start_cyc !== 6 + 4*DU) begin n_fail++; $display("FAIL delay_time: got %0d want %0d", done_cyc - start_cyc, 6 + 4*DU); end
        n_checks++; if (n_done !== 1 || act_len.size() !== 0) begin n_fail++; $display("FAIL delay_result: got done=%0d sends=%0d want 1 0", n_done, act_len.size()); end
    endtask

    task automatic test_retry();
        bit to, e_err; int e_addr;
        for (int k = 0; k < 2; k++) begin
            rom_clear(); ready_all = 1'b0;
            rom[10] = mk(2'b00, 6'd2, 32'hABCD0000);
            rom[11] = mk(2'b10, 6'd0, 32'h0);
            nack_plan.delete();
            if (k == 0) nack_plan = '{1'b1, 1'b1, 1'b0};
            else        nack_plan = '{1'b1, 1'b1, 1'b1, 1'b1};
            predict(10, e_err, e_addr);
            kick(10); wait_end(300, to);
            nack_plan.delete();
            n_checks++; if (to) begin n_fail++; $display("FAIL retry%0d_timeout: got no completion", k); end
            n_checks++; if (act_len.size() !== exp_len.size()) begin n_fail++; $display("FAIL retry%0d_nsend: got %0d want %0d", k, act_len.size(), exp_len.size()); end
            n_checks++; if (err_o !== e_err) begin n_fail++; $display("FAIL retry%0d_err: got %b want %b", k, err_o, e_err); end
            if (e_err) begin
                n_checks++; if (int'(err_addr_o) !== e_addr) begin n_fail++; $display("FAIL retry%0d_eaddr: got %0d want %0d", k, err_addr_o, e_addr); end
            end
        end
    endtask

    task automatic test_illegal();
        bit to;
        logic [EW-1:0] bad [3];
        bad[0] = mk(2'b11, 6'd2, 32'h11223344);
        bad[1] = mk(2'b00, 6'd0, 32'h55667788);
        bad[2] = mk(2'b00, 6'(NB+1), 32'h99AABBCC);
        for (int k = 0; k < 3; k++) begin
            rom_clear(); ready_all = 1'b0;
            rom[0] = mk(2'b00, 6'd1, 32'h5A000000);
            rom[1] = mk(2'b01, 6'd1, 32'h0);
            rom[2] = bad[k];
            kick(0); wait_end(300, to);
            n_checks++;
            if (to || err_o !== 1'b1 || err_addr_o !== 6'd2) begin
                n_fail++; $display("FAIL illegal%0d_err: got err=%b eaddr=%0d want 1 2", k, err_o, err_addr_o);
            end
            n_checks++;
            if (act_len.size() !== 1 || n_done !== 0 || n_both !== 0) begin
                n_fail++; $display("FAIL illegal%0d_sends: got sends=%0d done=%0d want 1 0", k, act_len.size(), n_done);
            end
        end
    endtask

    task automatic test_implicit_end();
        bit to;
        logic [31:0] pl;
        rom_clear(); ready_all = 1'b0;
        pl = $urandom;
        rom[DEPTH-1] = mk(2'b00, 6'd4, pl);
        kick(DEPTH-1); wait_end(200, to);
        n_checks++; if (to || n_done !== 1) begin n_fail++; $display("FAIL implicit_done: got %0d want 1", n_done); end
        n_checks++; if (act_len.size() !== 1 || (act_len.size() > 0 && act_data[0] !== pl)) begin
            n_fail++; $display("FAIL implicit_send: got %0d sends want 1 with data %h", act_len.size(), pl); end
        n_checks++; if (saw_zero !== 1'b0) begin n_fail++; $display("FAIL implicit_wrap: got rom_addr 0 seen, want never"); end
    endtask

    task automatic test_robust();
        bit to;
        int w;
        rom_clear(); ready_all = 1'b0;
        rom[20] = mk(2'b00, 6'd2, 32'h12340000);
        rom[21] = mk(2'b00, 6'd1, 32'h56000000);
        rom[22] = mk(2'b10, 6'd0, 32'h0);
        rom[30] = mk(2'b00, 6'd3, 32'hC0FFEE00);
        rom[31] = mk(2'b10, 6'd0, 32'h0);
        rom[40] = mk(2'b11, 6'd0, 32'h0);
        kick(20);
        repeat (4) @(posedge clk_i);
        #2 start_addr_i = 6'd40; start_i = 1'b1;
        @(posedge clk_i); #2 start_i = 1'b0;
        wait_end(300, to);
        n_checks++; if (to || n_done !== 1 || err_o !== 1'b0 || act_len.size() !== 2) begin
            n_fail++; $display("FAIL busy_start: got done=%0d err=%b sends=%0d want 1 0 2", n_done, err_o, act_len.size()); end
        // Reset while the sequencer waits on the engine
        eng_hold = 1'b1;
        kick(30);
        w = 0;
        while (act_len.size() == 0 && w < 50) begin @(negedge clk_i); w++; end
        n_checks++; if (act_len.size() == 0) begin n_fail++; $display("FAIL reset_wait_reach: got no send within 50 cycles"); end
        repeat (2) @(posedge clk_i);
        #3 rst_n_i = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, err_o, err_addr_o, rom_addr_o, i2c_send_o, i2c_nbytes_o, i2c_data_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b raddr=%0d nb=%0d data=%h want all 0", busy_o, rom_addr_o, i2c_nbytes_o, i2c_data_o);
        end
        eng_hold = 1'b0;
        @(posedge clk_i); #2 rst_n_i = 1'b1;
        kick(30); wait_end(200, to);
        n_checks++; if (to || n_done !== 1 || act_len.size() !== 1 || (act_len.size() > 0 && act_data[0] !== 32'hC0FFEE00)) begin
            n_fail++; $display("FAIL post_reset_run: got done=%0d sends=%0d want 1 1", n_done, act_len.size()); end
    endtask

    task automatic test_random();
        bit to, e_err;
        int e_addr, st, k, r;
        for (int it = 0; it < 8; it++) begin
            rom_clear(); ready_all = 1'b0; nack_plan.delete();
            st = int'($urandom_range(0, 40));
            k  = int'($urandom_range(1, 8));
            for (int a = st; a < st + k; a++) begin
                r = int'($urandom_range(0, 99));
                if (r < 70)      rom[a] = mk(2'b00, 6'($urandom_range(1, NB)), $urandom);
                else if (r < 88) rom[a] = mk(2'b01, 6'($urandom_range(0, 2)), $urandom);
                else if (r < 93) rom[a] = mk(2'b11, 6'($urandom_range(0, 63)), $urandom);
                else             rom[a] = mk(2'b00, 6'($urandom_range(NB+1, 63)), $urandom);
            end
            for (int n = 0; n < 6; n++) nack_plan.push_back($urandom_range(0, 99) < 30);
            predict(st, e_err, e_addr);
            kick(st); wait_end(2000, to);
            nack_plan.delete();
            n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: got no completion", it); end
            n_checks++; if (act_len.size() !== exp_len.size()) begin n_fail++; $display("FAIL rand%0d_nsend: got %0d want %0d", it, act_len.size(), exp_len.size()); end
            for (int i = 0; i < act_len.size() && i < exp_len.size(); i++) begin
                n_checks++;
                if (int'(act_len[i]) !== exp_len[i] || act_data[i] !== exp_data[i]) begin
                    n_fail++; $display("FAIL rand%0d_send%0d: got %0d/%h want %0d/%h", it, i, act_len[i], act_data[i], exp_len[i], exp_data[i]);
                end
            end
            n_checks++; if (err_o !== e_err || n_done !== (e_err ? 0 : 1) || n_both !== 0) begin
                n_fail++; $display("FAIL rand%0d_outcome: got err=%b done=%0d want err=%b", it, err_o, n_done, e_err); end
            if (e_err) begin
                n_checks++; if (int'(err_addr_o) !== e_addr) begin n_fail++; $display("FAIL rand%0d_eaddr: got %0d want %0d", it, err_addr_o, e_addr); end
            end
            n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy: got 1 want 0", it); end
        end
    endtask

    initial begin
        eng_hold = 1'b0; ready_all = 1'b1;
        rom_clear();
        test_reset();
        test_basic();
        test_delay();
        test_retry();
        test_illegal();
        test_implicit_end();
        test_robust();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
